// File: rtl/uart_srec_loader.sv
// uart_srec_loader: parses ASCII Motorola S3/S7 records arriving one character
// per byte_ready strobe and turns S3 payload into aligned 32-bit memory writes.
// S7 records report the start address and end the load. Other record types
// are skipped silently; malformed S3/S7 records raise a sticky error.
module uart_srec_loader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic        write_enable,
  output logic        loading,
  output logic        done,
  output logic [31:0] start_address,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_COUNT, S_ADDR, S_DATA, S_CSUM, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic        is_s7_q, is_s7_d;          // record type latched in TYPE
  logic [7:0]  count_q, count_d;          // record byte count N
  logic [2:0]  nib_cnt_q, nib_cnt_d;      // hex characters seen in current field/word
  logic [31:0] field_q, field_d;          // nibble shift register shared by all fields
  logic [31:0] addr_q, addr_d;            // running write address
  logic [7:0]  bytes_left_q, bytes_left_d;
  logic [7:0]  sum_q, sum_d;              // running 8-bit checksum
  logic [31:0] write_address_q, write_address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        write_enable_q, write_enable_d;
  logic        loading_q, loading_d;
  logic        done_q, done_d;
  logic [31:0] start_address_q, start_address_d;
  logic        error_q, error_d;

  logic        hex_ok;
  logic [3:0]  hex_val;
  logic [7:0]  hex_tmp;
  logic [7:0]  hex_byte;     // completed byte when this char is the low nibble
  logic [31:0] field_shift;  // field after shifting in this char
  logic [7:0]  data_rem;     // N - 5 = number of payload bytes

  // Decode the incoming character as a hex digit.
  always_comb begin
    hex_ok  = 1'b0;
    hex_tmp = 8'h00;
    if (byte_data >= 8'h30 && byte_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_tmp = byte_data - 8'h30;
    end else if (byte_data >= 8'h41 && byte_data <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_tmp = byte_data - 8'h37;
    end else if (byte_data >= 8'h61 && byte_data <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_tmp = byte_data - 8'h57;
    end
    hex_val     = hex_tmp[3:0];
    hex_byte    = {field_q[3:0], hex_val};
    field_shift = {field_q[27:0], hex_val};
    data_rem    = count_q - 8'd5;
  end

  // Next-state and output computation; everything holds unless a character arrives.
  always_comb begin
    state_d         = state_q;
    is_s7_d         = is_s7_q;
    count_d         = count_q;
    nib_cnt_d       = nib_cnt_q;
    field_d         = field_q;
    addr_d          = addr_q;
    bytes_left_d    = bytes_left_q;
    sum_d           = sum_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    write_enable_d  = 1'b0;
    loading_d       = loading_q;
    done_d          = 1'b0;
    start_address_d = start_address_q;
    error_d         = error_q;

    if (byte_ready) begin
      case (state_q)
        S_IDLE: begin
          if (byte_data == 8'h53)                             state_d = S_TYPE;
          else if (byte_data != 8'h0D && byte_data != 8'h0A)  state_d = S_SKIP;
        end
        S_TYPE: begin
          nib_cnt_d = 3'd0;
          if (byte_data == 8'h33) begin
            is_s7_d = 1'b0;
            state_d = S_COUNT;
          end else if (byte_data == 8'h37) begin
            is_s7_d = 1'b1;
            state_d = S_COUNT;
          end else begin
            state_d = S_SKIP;
          end
        end
        S_COUNT, S_ADDR, S_DATA, S_CSUM: begin
          if (!hex_ok) begin
            error_d = 1'b1;
            state_d = S_SKIP;
          end else begin
            field_d   = field_shift;
            nib_cnt_d = nib_cnt_q + 3'd1;
            case (state_q)
              S_COUNT: begin
                if (nib_cnt_q == 3'd1) begin
                  count_d   = hex_byte;
                  sum_d     = hex_byte;
                  nib_cnt_d = 3'd0;
                  if ((is_s7_q && hex_byte != 8'd5) || (!is_s7_q && hex_byte < 8'd5)) begin
                    error_d = 1'b1;
                    state_d = S_SKIP;
                  end else begin
                    state_d = S_ADDR;
                  end
                end
              end
              S_ADDR: begin
                if (nib_cnt_q[0]) sum_d = sum_q + hex_byte;
                if (nib_cnt_q == 3'd7) begin
                  addr_d       = field_shift;
                  bytes_left_d = data_rem;
                  nib_cnt_d    = 3'd0;
                  if (!is_s7_q && field_shift[1:0] != 2'b00) begin
                    error_d = 1'b1;
                    state_d = S_SKIP;
                  end else if (count_q == 8'd5) begin
                    state_d = S_CSUM;
                  end else begin
                    state_d = S_DATA;
                  end
                end
              end
              S_DATA: begin
                // A completed word is written as soon as its 8th digit lands.
                if (nib_cnt_q == 3'd7) begin
                  write_enable_d  = 1'b1;
                  write_address_d = addr_q;
                  write_data_d    = field_shift;
                  addr_d          = addr_q + 32'd4;
                  loading_d       = 1'b1;
                end
                if (nib_cnt_q[0]) begin
                  sum_d        = sum_q + hex_byte;
                  bytes_left_d = bytes_left_q - 8'd1;
                  if (bytes_left_q == 8'd1) begin
                    nib_cnt_d = 3'd0;
                    state_d   = S_CSUM;
                  end
                end
              end
              default: begin  // S_CSUM
                if (nib_cnt_q == 3'd1) begin
                  // A trailing partial word is dropped and flagged.
                  if (hex_byte != ~sum_q || data_rem[1:0] != 2'b00) error_d = 1'b1;
                  if (is_s7_q) begin
                    start_address_d = addr_q;
                    done_d          = 1'b1;
                    loading_d       = 1'b0;
                  end
                  state_d = S_SKIP;
                end
              end
            endcase
          end
        end
        default: begin  // S_SKIP
          if (byte_data == 8'h0A) state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register all parser state and outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      is_s7_q         <= 1'b0;
      count_q         <= 8'h00;
      nib_cnt_q       <= 3'd0;
      field_q         <= 32'h0;
      addr_q          <= 32'h0;
      bytes_left_q    <= 8'h00;
      sum_q           <= 8'h00;
      write_address_q <= 32'h0;
      write_data_q    <= 32'h0;
      write_enable_q  <= 1'b0;
      loading_q       <= 1'b0;
      done_q          <= 1'b0;
      start_address_q <= 32'h0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_s7_q         <= is_s7_d;
      count_q         <= count_d;
      nib_cnt_q       <= nib_cnt_d;
      field_q         <= field_d;
      addr_q          <= addr_d;
      bytes_left_q    <= bytes_left_d;
      sum_q           <= sum_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_enable_q  <= write_enable_d;
      loading_q       <= loading_d;
      done_q          <= done_d;
      start_address_q <= start_address_d;
      error_q         <= error_d;
    end
  end

  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign write_enable  = write_enable_q;
  assign loading       = loading_q;
  assign done          = done_q;
  assign start_address = start_address_q;
  assign error         = error_q;

endmodule

// File: tb/tb_uart_srec_loader.sv
// tb_uart_srec_loader: directed S-record streams with hand-computed checksums
// and expected write transactions.
module tb_uart_srec_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] write_address, write_data, start_address;
  logic        write_enable, loading, done, error;

  int n_run  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  uart_srec_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .write_address(write_address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .loading      (loading),
    .done         (done),
    .start_address(start_address),
    .error        (error)
  );

  always #5 clock = ~clock;

  // Capture every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (write_enable) begin
      wr_cnt++;
      wq_addr.push_back(write_address);
      wq_data.push_back(write_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_str(input string s, input bit b2b);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      byte_data  = s[i];
      byte_ready = 1'b1;
      if (!b2b) begin
        @(negedge clock);
        byte_ready = 1'b0;
      end
    end
    @(negedge clock);
    byte_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  int wb, db;

  initial begin
    reset_n    = 1'b0;
    byte_data  = 8'h00;
    byte_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_waddr", write_address, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_we", {31'h0, write_enable}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_start", start_address, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    reset_n = 1'b1;

    // Single-word record, spaced strobes.
    wb = wr_cnt; db = done_cnt;
    send_str("S30900000000DEADBEEFBE\r\n", 1'b0);
    chk("r1_nwr", wr_cnt - wb, 1);
    chk("r1_addr", wq_addr[wb], 32'h0);
    chk("r1_data", wq_data[wb], 32'hDEADBEEF);
    chk("r1_loading", {31'h0, loading}, 32'h1);
    chk("r1_error", {31'h0, error}, 32'h0);
    chk("r1_done", done_cnt - db, 0);

    // Two-word record, back-to-back strobes.
    do_reset();
    wb = wr_cnt;
    send_str("S30D0000001011223344AABBCCDD2A\n", 1'b1);
    chk("r2_nwr", wr_cnt - wb, 2);
    chk("r2_addr0", wq_addr[wb], 32'h10);
    chk("r2_data0", wq_data[wb], 32'h11223344);
    chk("r2_addr1", wq_addr[wb+1], 32'h14);
    chk("r2_data1", wq_data[wb+1], 32'hAABBCCDD);
    chk("r2_error", {31'h0, error}, 32'h0);

    // Bad checksum: write still happens, error rises on the last checksum char.
    do_reset();
    wb = wr_cnt;
    send_str("S30900000000DEADBEEF", 1'b0);
    chk("cs_nwr", wr_cnt - wb, 1);
    chk("cs_data", wq_data[wb], 32'hDEADBEEF);
    send_str("B", 1'b0);
    chk("cs_err_mid", {31'h0, error}, 32'h0);
    send_str("F", 1'b0);
    chk("cs_err_set", {31'h0, error}, 32'h1);
    send_str("\r\nS", 1'b0);
    chk("cs_err_sticky", {31'h0, error}, 32'h1);

    // Header skipped, S7 terminates; then a load followed by S7 with an address.
    do_reset();
    wb = wr_cnt; db = done_cnt;
    send_str("S00600004844521B\nS70500000000FA\n", 1'b1);
    chk("s7_nwr", wr_cnt - wb, 0);
    chk("s7_done", done_cnt - db, 1);
    chk("s7_start", start_address, 32'h0);
    chk("s7_loading", {31'h0, loading}, 32'h0);
    chk("s7_error", {31'h0, error}, 32'h0);
    send_str("S30900000000DEADBEEFBE\n", 1'b1);
    chk("s7b_loading_on", {31'h0, loading}, 32'h1);
    send_str("S70500001000EA\n", 1'b1);
    chk("s7b_done", done_cnt - db, 2);
    chk("s7b_start", start_address, 32'h00001000);
    chk("s7b_loading_off", {31'h0, loading}, 32'h0);
    chk("s7b_error", {31'h0, error}, 32'h0);

    // Invalid hex digit kills the record; the next line still loads.
    do_reset();
    wb = wr_cnt;
    send_str("S30900000000DEGDBEEFBE\n", 1'b0);
    chk("hex_error", {31'h0, error}, 32'h1);
    chk("hex_nwr", wr_cnt - wb, 0);
    send_str("S30900000004CAFEBABEB2\n", 1'b0);
    chk("hex_next_nwr", wr_cnt - wb, 1);
    chk("hex_next_addr", wq_addr[wb], 32'h4);
    chk("hex_next_data", wq_data[wb], 32'hCAFEBABE);

    // Partial trailing word: discarded and flagged.
    do_reset();
    wb = wr_cnt;
    send_str("S3060000000011E8\n", 1'b1);
    chk("part_nwr", wr_cnt - wb, 0);
    chk("part_error", {31'h0, error}, 32'h1);

    // Misaligned S3 address.
    do_reset();
    wb = wr_cnt;
    send_str("S30900000002DEADBEEFBC\n", 1'b1);
    chk("align_nwr", wr_cnt - wb, 0);
    chk("align_error", {31'h0, error}, 32'h1);

    // Bad S7 count.
    do_reset();
    db = done_cnt;
    send_str("S70600000000F9\n", 1'b1);
    chk("s7cnt_error", {31'h0, error}, 32'h1);
    chk("s7cnt_done", done_cnt - db, 0);

    // Reset mid-record clears outputs at once and drops the partial word.
    do_reset();
    send_str("S30900000000DEADBEEFBE\nS30900000000DEAD", 1'b0);
    wb = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_wdata", write_data, 32'h0);
    chk("mid_loading", {31'h0, loading}, 32'h0);
    chk("mid_error", {31'h0, error}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    send_str("BEEFBE\n", 1'b0);
    chk("mid_nowr", wr_cnt - wb, 0);
    send_str("S30900000004CAFEBABEB2\n", 1'b0);
    chk("mid_after_nwr", wr_cnt - wb, 1);
    chk("mid_after_addr", wq_addr[wb], 32'h4);
    chk("mid_after_data", wq_data[wb], 32'hCAFEBABE);
    chk("mid_after_error", {31'h0, error}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_srec_loader.md
# uart_srec_loader

Consumes the byte stream produced by the UART receiver and parses ASCII Motorola S-records (S3 data, S7 termination) into 32-bit memory write transactions. Sits between the UART receiver and the system memory write port, so a host can load a program image over the serial line before the CPU is released from reset. Records other than S3/S7 are skipped.

## Interface
- Parameters: none.
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- byte_data  in  8  received ASCII character; valid when byte_ready is high
- byte_ready  in  1  one-cycle strobe, one character per strobe
- write_address  out  32  byte address of the word being written (word aligned)
- write_data  out  32  word to write; first record byte in [31:24]
- write_enable  out  1  one-cycle write strobe; memory accepts every strobe
- loading  out  1  high from first accepted S3 record until S7 accepted
- done  out  1  one-cycle pulse when an S7 record completes
- start_address  out  32  address field of the last S7 record
- error  out  1  sticky error flag, cleared only by reset

## Operation
- Everything advances only on cycles with byte_ready high; otherwise all state holds.
- Hex decode: '0'-'9', 'A'-'F', 'a'-'f' give 0-15. Any other character inside a hex field sets error and moves to SKIP.
- States:
  - IDLE: 'S' -> TYPE. CR and LF are ignored. Any other character -> SKIP, with no error.
  - TYPE: '3' or '7' -> COUNT, and the record type is latched. Any other character -> SKIP, with no error (covers S0/S5 etc.).
  - COUNT: two hex characters form count N.
    - For S3, N < 5 sets error -> SKIP.
    - For S7, N != 5 sets error -> SKIP.
  - ADDR: eight hex characters, most significant first, form a 32-bit address.
    - For S3, address[1:0] != 0 sets error -> SKIP.
    - Then -> DATA if N-5 > 0, else -> CHECKSUM.
  - DATA: N-5 bytes, two hex characters each, shifted into a 32-bit word MSB-first.
    - After every 4th byte, write_enable pulses with write_address = current address, and the address increments by 4.
    - After the last byte -> CHECKSUM.
  - CHECKSUM: two hex characters.
    - Expected value = ones' complement of the low 8 bits of the sum of N, the 4 address bytes and all data bytes. A mismatch sets error.
    - If (N-5) mod 4 != 0, the trailing partial word is discarded and error is set.
    - For S7: start_address is updated, done pulses, loading clears (mismatch still sets error but done still fires).
    - Then -> SKIP.
  - SKIP: discard characters until LF, then -> IDLE. An 'S' in SKIP is discarded.
- loading rises together with the first write_enable of an S3 record.
- Address arithmetic wraps modulo 2^32.
- The checksum accumulator is 8 bits and wraps.
- Writes already issued are never retracted by a later checksum error.

## Timing
- Reset values: write_address 0, write_data 0, write_enable 0, loading 0, done 0, start_address 0, error 0, state IDLE.
- write_enable asserts in the cycle after the byte_ready that delivers the 8th hex character of a word, and is high for exactly one cycle. write_address and write_data are valid in that cycle and hold until the next write.
- done asserts in the cycle after the byte_ready of the second S7 checksum character, for one cycle. start_address is valid in the same cycle.
- error rises in the cycle after the offending character.
- Back-to-back byte_ready strobes (every cycle) are supported with no lost characters.
- reset_n low mid-record: outputs return to reset values immediately; a partial word is never written.

## Test plan
- "S30900000000DEADBEEFBE\r\n" -> exactly one write: address 0x00000000, data 0xDEADBEEF. loading=1 afterwards, error=0.
- "S30D0000001011223344AABBCCDD" + correct checksum + "\n" -> writes (0x10, 0x11223344) then (0x14, 0xAABBCCDD), on consecutive words. error=0.
- Same record as the first with checksum "BF" -> write of 0xDEADBEEF still occurs; error=1 after the checksum character and stays 1.
- "S0..." header line, then "S70500000000FA\n" -> no writes; done pulses once; start_address=0x00000000; loading=0; error=0.
- "S30900000000DEGDBEEF..." -> error=1, no write. The following valid S3 record on the next line is still written correctly.
- Assert reset_n low after "S309000000" -> all outputs 0. A fresh record after release parses normally.
